// File: rtl/cache_bank_arbiter.sv
// Round-robin arbiter sharing one dual-port cache bank among NUM_REQ requesters.
// Grants up to two requests per cycle (one per port); responses return exactly one cycle after acceptance.
module cache_bank_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [ADDR_WIDTH-1:0]          bank_addr_a,
    output logic [ADDR_WIDTH-1:0]          bank_addr_b,
    output logic [DATA_WIDTH-1:0]          bank_wdata_a,
    output logic [DATA_WIDTH-1:0]          bank_wdata_b,
    output logic                           bank_wen_n_a,
    output logic                           bank_wen_n_b,
    input  logic [DATA_WIDTH-1:0]          bank_rdata_a,
    input  logic [DATA_WIDTH-1:0]          bank_rdata_b,
    input  logic                           bank_written_a,
    input  logic                           bank_written_b,
    output logic                           rsp_valid_a,
    output logic                           rsp_valid_b,
    output logic [ID_WIDTH-1:0]            rsp_id_a,
    output logic [ID_WIDTH-1:0]            rsp_id_b,
    output logic                           rsp_write_a,
    output logic                           rsp_write_b,
    output logic [DATA_WIDTH-1:0]          rsp_rdata_a,
    output logic [DATA_WIDTH-1:0]          rsp_rdata_b,
    output logic                           rsp_written_a,
    output logic                           rsp_written_b
);

    typedef enum logic {HOLD, ACTIVE} state_t;

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    state_t state, state_next;
    logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_next;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic                  active;
    logic                  found_a, found_b, hazard;
    logic                  gnt_a, gnt_b;
    logic [ID_WIDTH-1:0]   win_a, win_b;

    logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;
    logic                  rsp_vld_a_q, rsp_vld_b_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Explicit wrap so non-power-of-two NUM_REQ never leaves the valid index range.
    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        return (id == LAST_ID) ? '0 : id + ID_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HOLD;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HOLD:    state_next = ACTIVE;
            ACTIVE:  state_next = ACTIVE;
            default: state_next = HOLD;
        endcase
    end

    assign active = (state == ACTIVE) && !reset;

    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        found_a = 1'b0;
        win_a   = '0;
        idx     = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_a && req_valid[idx]) begin
                found_a = 1'b1;
                win_a   = idx;
            end
            idx = next_id(idx);
        end
        found_b = 1'b0;
        win_b   = '0;
        idx     = next_id(win_a);
        for (int k = 1; k < NUM_REQ; k++) begin
            if (found_a && !found_b && req_valid[idx]) begin
                found_b = 1'b1;
                win_b   = idx;
            end
            idx = next_id(idx);
        end
    end

    // A write colliding with any access to the same line keeps port B idle this cycle.
    assign hazard = (addr_arr[win_a] == addr_arr[win_b]) && (req_write[win_a] || req_write[win_b]);
    assign gnt_a  = active && found_a;
    assign gnt_b  = active && found_b && !hazard;

    always_comb begin
        req_ready = '0;
        if (gnt_a) req_ready[win_a] = 1'b1;
        if (gnt_b) req_ready[win_b] = 1'b1;
    end

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (gnt_b)      rr_ptr_next = next_id(win_b);
        else if (gnt_a) rr_ptr_next = next_id(win_a);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            wdata_a_q   <= '0;
            wdata_b_q   <= '0;
            rsp_vld_a_q <= 1'b0;
            rsp_vld_b_q <= 1'b0;
            rsp_id_a    <= '0;
            rsp_id_b    <= '0;
            rsp_write_a <= 1'b0;
            rsp_write_b <= 1'b0;
        end else begin
            if (gnt_a) begin
                addr_a_q  <= addr_arr[win_a];
                wdata_a_q <= wdata_arr[win_a];
            end
            if (gnt_b) begin
                addr_b_q  <= addr_arr[win_b];
                wdata_b_q <= wdata_arr[win_b];
            end
            rsp_vld_a_q <= gnt_a;
            rsp_vld_b_q <= gnt_b;
            rsp_id_a    <= win_a;
            rsp_id_b    <= win_b;
            rsp_write_a <= req_write[win_a];
            rsp_write_b <= req_write[win_b];
        end
    end

    // Reset gates the outputs combinationally so they are quiet from the first reset cycle.
    assign bank_addr_a   = reset ? '0 : (gnt_a ? addr_arr[win_a]  : addr_a_q);
    assign bank_addr_b   = reset ? '0 : (gnt_b ? addr_arr[win_b]  : addr_b_q);
    assign bank_wdata_a  = reset ? '0 : (gnt_a ? wdata_arr[win_a] : wdata_a_q);
    assign bank_wdata_b  = reset ? '0 : (gnt_b ? wdata_arr[win_b] : wdata_b_q);
    assign bank_wen_n_a  = ~(gnt_a && req_write[win_a]);
    assign bank_wen_n_b  = ~(gnt_b && req_write[win_b]);

    assign rsp_valid_a   = rsp_vld_a_q && !reset;
    assign rsp_valid_b   = rsp_vld_b_q && !reset;
    assign rsp_rdata_a   = bank_rdata_a;
    assign rsp_rdata_b   = bank_rdata_b;
    assign rsp_written_a = bank_written_a;
    assign rsp_written_b = bank_written_b;

endmodule

// File: doc/cache_bank_arbiter.md
Name: cache_bank_arbiter

Overview:
Shares one dual-port cache bank (ports A and B, 1-cycle synchronous read, active-low write enable, per-line written-to flag) among NUM_REQ requesters. Grants up to two requests per cycle, one per bank port, by round-robin. It blocks same-address hazards within a cycle and routes registered read data and written-to flags back to the requester that issued the read. It sits between the processing-element load/store units and a single cache bank.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 8, bank line address width
ID_WIDTH, 2, requester index width, equal to clog2(NUM_REQ)

Ports:
clk  in  1  clock, all logic on the rising edge
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  request pending, one bit per requester
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same slicing
req_ready  out  NUM_REQ  request accepted this cycle (combinational grant)
bank_addr_a / bank_addr_b  out  ADDR_WIDTH  bank port addresses
bank_wdata_a / bank_wdata_b  out  DATA_WIDTH  bank port write data
bank_wen_n_a / bank_wen_n_b  out  1  active-low write enable, 0 = write
bank_rdata_a / bank_rdata_b  in  DATA_WIDTH  bank read data, valid 1 cycle after address
bank_written_a / bank_written_b  in  1  bank written-to flag, valid 1 cycle after a read
rsp_valid_a / rsp_valid_b  out  1  response valid on port lane
rsp_id_a / rsp_id_b  out  ID_WIDTH  requester that owns the response
rsp_write_a / rsp_write_b  out  1  response acknowledges a write, so data is don't-care
rsp_rdata_a / rsp_rdata_b  out  DATA_WIDTH  read data
rsp_written_a / rsp_written_b  out  1  line had been written before this read

Behaviour:
- Reset is synchronous and active-high; the clock is clk. While reset is high:
  - rr_ptr is 0;
  - state is HOLD;
  - all req_ready are 0;
  - rsp_valid_a and rsp_valid_b are 0;
  - bank_wen_n_a and bank_wen_n_b are 1;
  - bank addresses and write data are 0.
- FSM: HOLD -> ACTIVE on the first cycle after reset deasserts. HOLD grants nothing for exactly one cycle, which lets the bank finish clearing its written-to flags. ACTIVE stays until reset.
- Port A grant: the first requester with req_valid, searching circularly from rr_ptr.
- Port B grant: the next valid requester after the port A winner, again circular, excluding the A winner.
  - B is withheld if its address equals A's address and either request is a write.
  - When B is withheld, that requester retries with no loss of state.
- req_ready[i] = 1 only for granted requesters and only in ACTIVE. A request is accepted when req_valid and req_ready are both high. Requesters hold valid, write, addr and wdata stable until accepted.
- Bank drive is combinational from the grants:
  - bank_wen_n_x = ~req_write of the winner;
  - an ungranted port drives bank_wen_n_x = 1, and its address/data hold their previous values.
- rr_ptr update (registered):
  - after B is granted: (B winner + 1) mod NUM_REQ;
  - else after only A is granted: (A winner + 1) mod NUM_REQ;
  - else unchanged.
- Response latency is exactly 1 cycle after acceptance, for reads and writes alike. On that cycle, for each port lane:
  - rsp_valid_x = 1;
  - rsp_id_x = the winner's index;
  - rsp_write_x = the winner's req_write;
  - rsp_rdata_x and rsp_written_x pass bank_rdata_x and bank_written_x straight through. They are valid only for reads.
- Fully pipelined: a new grant every cycle. A requester may be accepted on back-to-back cycles.
- A single requester is never granted both ports in one cycle.
- Reset mid-operation: an in-flight response is dropped, so rsp_valid is 0 on the cycle after reset. The FSM re-enters HOLD.
- NUM_REQ not a power of two: the modulo wrap is explicit, and the pointer never exceeds NUM_REQ-1.

Test Plan:
- Reset then idle: during reset and the HOLD cycle, req_valid=4'b1111 -> req_ready=0, wen_n=1. The first ACTIVE cycle grants requesters 0 (port A) and 1 (port B), and rr_ptr becomes 2.
- Read-after-write, one requester: requester 2 writes 0xDEADBEEF to address 0x10. The next cycle it reads 0x10 -> rsp_valid_a=1, rsp_id_a=2, rsp_rdata_a=0xDEADBEEF, rsp_written_a=1. A read of never-written address 0x11 returns rsp_written=0.
- Round-robin fairness: all 4 requesters valid continuously with distinct addresses, 8 cycles -> grant pairs cycle (0,1), (2,3), (0,1)... Each requester gets 4 grants with no starvation.
- Address hazard: requester 0 writes 0x20 while requester 1 reads 0x20 -> only 0 is granted. Requester 1 is granted the next cycle and reads the new data with rsp_written=1. Two reads of 0x20 are both granted in the same cycle.
- Single requester: only requester 3 is valid for 3 cycles -> port A only, bank_wen_n_b=1, rsp_valid_b=0, rr_ptr stays at 0 after each grant.
- Reset mid-flight: a read is granted at cycle N and reset is asserted at N+1 -> rsp_valid_a=0 at N+1. After reset releases there is one HOLD cycle, then normal grants resume from requester 0.
